// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM keystream scheduler: block width, FSM states,
// job tags and the 32-bit counter increment used by CTR mode.
package gcm_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    JOB_H  = 2'd0,
    JOB_TM = 2'd1,
    JOB_KS = 2'd2
  } job_e;

  // Only the low word counts; the upper 96 bits of the block never change.
  function automatic logic [BLK_W-1:0] inc32(input logic [BLK_W-1:0] x);
    return {x[BLK_W-1:32], x[31:0] + 32'd1};
  endfunction

endpackage

// File: rtl/ctr_ks_sched_if.sv
// Bundle of configuration, result and AES-core handshake signals around the
// keystream scheduler; master is the scheduler side, slave its environment.
interface ctr_ks_sched_if;
  import gcm_pkg::*;

  logic             cfg_load;
  logic [BLK_W-1:0] cfg_j0;
  logic             h_valid;
  logic [BLK_W-1:0] h_data;
  logic             tm_req;
  logic             tm_valid;
  logic [BLK_W-1:0] tm_data;
  logic             ks_req;
  logic             ks_valid;
  logic             ks_ready;
  logic [BLK_W-1:0] ks_data;
  logic             aes_start;
  logic [BLK_W-1:0] aes_din;
  logic             aes_done;
  logic [BLK_W-1:0] aes_dout;
  logic             busy;

  modport master (
    input  cfg_load, cfg_j0, tm_req, ks_req, ks_ready, aes_done, aes_dout,
    output h_valid, h_data, tm_valid, tm_data, ks_valid, ks_data,
           aes_start, aes_din, busy
  );

  modport slave (
    output cfg_load, cfg_j0, tm_req, ks_req, ks_ready, aes_done, aes_dout,
    input  h_valid, h_data, tm_valid, tm_data, ks_valid, ks_data,
           aes_start, aes_din, busy
  );

endinterface

// File: rtl/ctr_ks_sched.sv
// Shares one AES core between the hash subkey, the tag mask and CTR keystream
// blocks; fixed priority H > TM > KS, one job in flight, one-entry ks buffer.
module ctr_ks_sched
  import gcm_pkg::*;
#(
  parameter bit PREFETCH = 1'b1
) (
  input logic            clk,
  input logic            rst,
  ctr_ks_sched_if.master bus
);

  state_e           state_q, state_d;
  job_e             job_q, job_d;
  logic             configured_q, configured_d;
  logic             drop_q, drop_d;
  logic             pend_h_q, pend_h_d;
  logic             pend_tm_q, pend_tm_d;
  logic             h_valid_q, h_valid_d;
  logic             tm_valid_q, tm_valid_d;
  logic             ks_valid_q, ks_valid_d;
  logic [BLK_W-1:0] j0_q, j0_d;
  logic [BLK_W-1:0] ctr_q, ctr_d;
  logic [BLK_W-1:0] din_q, din_d;
  logic [BLK_W-1:0] h_data_q, h_data_d;
  logic [BLK_W-1:0] tm_data_q, tm_data_d;
  logic [BLK_W-1:0] ks_data_q, ks_data_d;

  logic is_idle, gnt_h, gnt_tm, gnt_ks, grant, done_w, done_ok;

  // A cfg_load cycle never grants: the restart re-arms the H job first.
  always_comb begin
    is_idle = (state_q == ST_IDLE);
    gnt_h   = is_idle && !bus.cfg_load && pend_h_q;
    gnt_tm  = is_idle && !bus.cfg_load && !pend_h_q && pend_tm_q;
    gnt_ks  = is_idle && !bus.cfg_load && !pend_h_q && !pend_tm_q &&
              configured_q && !ks_valid_q && (bus.ks_req || PREFETCH);
    grant   = gnt_h || gnt_tm || gnt_ks;
    done_w  = (state_q == ST_WAIT) && bus.aes_done;
    done_ok = done_w && !drop_q && !bus.cfg_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (bus.aes_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.aes_start = (state_q == ST_ISSUE);
    bus.busy      = !is_idle || pend_h_q || pend_tm_q;
  end

  always_comb begin
    configured_d = configured_q;
    pend_h_d     = pend_h_q;
    pend_tm_d    = pend_tm_q;
    h_valid_d    = h_valid_q;
    ks_valid_d   = ks_valid_q;
    j0_d         = j0_q;
    ctr_d        = ctr_q;
    din_d        = din_q;
    job_d        = job_q;
    h_data_d     = h_data_q;
    tm_data_d    = tm_data_q;
    ks_data_d    = ks_data_q;
    tm_valid_d   = done_ok && (job_q == JOB_TM);

    // Discard the next completion only if it is still to come.
    drop_d = drop_q;
    if (bus.cfg_load && ((state_q == ST_ISSUE) || ((state_q == ST_WAIT) && !bus.aes_done)))
      drop_d = 1'b1;
    else if (done_w)
      drop_d = 1'b0;

    if (bus.cfg_load) begin
      configured_d = 1'b1;
      j0_d         = bus.cfg_j0;
      ctr_d        = inc32(bus.cfg_j0);
      pend_h_d     = 1'b1;
      pend_tm_d    = 1'b0;
      h_valid_d    = 1'b0;
      ks_valid_d   = 1'b0;
    end else begin
      if (gnt_h) pend_h_d = 1'b0;
      if (gnt_tm)                             pend_tm_d = 1'b0;
      else if (bus.tm_req && configured_q)    pend_tm_d = 1'b1;
      if (gnt_ks) ctr_d = inc32(ctr_q);
      if (ks_valid_q && bus.ks_ready) ks_valid_d = 1'b0;
      if (done_ok) begin
        case (job_q)
          JOB_H: begin
            h_valid_d = 1'b1;
            h_data_d  = bus.aes_dout;
          end
          JOB_TM:  tm_data_d = bus.aes_dout;
          JOB_KS: begin
            ks_valid_d = 1'b1;
            ks_data_d  = bus.aes_dout;
          end
          default: ;
        endcase
      end
    end

    // aes_din is captured at grant and then held until the job completes.
    if (gnt_h) begin
      din_d = '0;
      job_d = JOB_H;
    end else if (gnt_tm) begin
      din_d = j0_q;
      job_d = JOB_TM;
    end else if (gnt_ks) begin
      din_d = ctr_q;
      job_d = JOB_KS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      configured_q <= 1'b0;
      drop_q       <= 1'b0;
      pend_h_q     <= 1'b0;
      pend_tm_q    <= 1'b0;
      h_valid_q    <= 1'b0;
      tm_valid_q   <= 1'b0;
      ks_valid_q   <= 1'b0;
      job_q        <= JOB_H;
      j0_q         <= '0;
      ctr_q        <= '0;
      din_q        <= '0;
      h_data_q     <= '0;
      tm_data_q    <= '0;
      ks_data_q    <= '0;
    end else begin
      configured_q <= configured_d;
      drop_q       <= drop_d;
      pend_h_q     <= pend_h_d;
      pend_tm_q    <= pend_tm_d;
      h_valid_q    <= h_valid_d;
      tm_valid_q   <= tm_valid_d;
      ks_valid_q   <= ks_valid_d;
      job_q        <= job_d;
      j0_q         <= j0_d;
      ctr_q        <= ctr_d;
      din_q        <= din_d;
      h_data_q     <= h_data_d;
      tm_data_q    <= tm_data_d;
      ks_data_q    <= ks_data_d;
    end
  end

  assign bus.h_valid  = h_valid_q;
  assign bus.h_data   = h_data_q;
  assign bus.tm_valid = tm_valid_q;
  assign bus.tm_data  = tm_data_q;
  assign bus.ks_valid = ks_valid_q;
  assign bus.ks_data  = ks_data_q;
  assign bus.aes_din  = din_q;

endmodule
